// File: rtl/iic_pkg.sv
// Shared definitions for the N-channel I2C op arbiter: op word layout,
// arbiter state encoding and a read-data return helper.
package iic_pkg;

  localparam int OP_W     = 12;
  localparam int OP_LOCK  = 11;
  localparam int OP_STOP  = 10;
  localparam int OP_START = 9;
  localparam int OP_RNW   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  // Writes carry no read byte back to the channel.
  function automatic logic [7:0] rd_return(input logic rnw, input logic [7:0] rd);
    return rnw ? rd : 8'h00;
  endfunction

endpackage

// File: rtl/iic_op_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last',
// wrapping modulo N_CH, so 'last' itself has the lowest priority.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  logic [CH_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_W'((int'(last) + i) % N_CH);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/iic_op_arbiter.sv
// N-channel round-robin op arbiter in front of the I2C byte engine, with lock
// holding for atomic multi-byte transactions. Optional idle-lock revocation
// is built when IIC_ARB_HOLD_TIMEOUT_EN is defined.
module iic_op_arbiter
  import iic_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int TO_W         = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [N_CH-1:0]      ch_op_valid,
  input  logic [OP_W*N_CH-1:0] ch_op_word,
  output logic [N_CH-1:0]      ch_op_pop,
  output logic [N_CH-1:0]      ch_op_done,
  output logic                 ch_op_err,
  output logic [7:0]           ch_rd_data,
  output logic                 eng_op_valid,
  output logic                 eng_op_start,
  output logic                 eng_op_stop,
  output logic                 eng_op_rnw,
  output logic [7:0]           eng_op_wr_data,
  input  logic                 eng_op_ack,
  input  logic                 eng_op_err,
  input  logic [7:0]           eng_rd_data,
  output logic [CH_W-1:0]      arb_sel,
  output logic                 arb_locked,
  output logic                 hold_timeout
);

  arb_state_e      state_reg;
  logic [OP_W-1:0] op_reg;
  logic [CH_W-1:0] sel_reg;
  logic [CH_W-1:0] last_reg;
  logic            locked_reg;
  logic            eng_valid_reg;
  logic [N_CH-1:0] done_reg;
  logic            err_reg;
  logic [7:0]      rd_reg;
  logic            timeout_reg;

  logic [CH_W-1:0] pick_idx;
  logic            pick_any;
  logic [CH_W-1:0] pop_idx;
  logic            pop_en;
  logic [OP_W-1:0] pop_word;
  logic [OP_W-1:0] word_arr [N_CH];

  // A timeout that cannot be represented in TO_W bits would never fire.
  if (HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > (1 << TO_W)) begin : g_hold_timeout_range_invalid
  end

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .req     (ch_op_valid),
    .last    (last_reg),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign word_arr[gi]  = ch_op_word[gi*OP_W +: OP_W];
      assign ch_op_pop[gi] = pop_en && (pop_idx == CH_W'(gi));
    end
  endgenerate

  // Pops are gated by reset so every output reads 0 while it is held.
  always_comb begin
    pop_en  = 1'b0;
    pop_idx = pick_idx;
    if (!wb_rst_i) begin
      case (state_reg)
        IDLE: pop_en = pick_any;
        HOLD: begin
          pop_en  = ch_op_valid[sel_reg];
          pop_idx = sel_reg;
        end
        default: pop_en = 1'b0;
      endcase
    end
  end

  assign pop_word = word_arr[pop_idx];

`ifdef IIC_ARB_HOLD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HOLD_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_reg;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      sel_reg       <= '0;
      last_reg      <= CH_W'(N_CH - 1);
      locked_reg    <= 1'b0;
      eng_valid_reg <= 1'b0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
      rd_reg        <= 8'h00;
      timeout_reg   <= 1'b0;
`ifdef IIC_ARB_HOLD_TIMEOUT_EN
      to_cnt_reg    <= '0;
`endif
    end else begin
      done_reg    <= '0;
      err_reg     <= 1'b0;
      rd_reg      <= 8'h00;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop_en) begin
            op_reg        <= pop_word;
            sel_reg       <= pop_idx;
            last_reg      <= pop_idx;
            eng_valid_reg <= 1'b1;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          if (eng_op_ack) begin
            eng_valid_reg     <= 1'b0;
            done_reg[sel_reg] <= 1'b1;
            err_reg           <= eng_op_err;
            rd_reg            <= rd_return(op_reg[OP_RNW], eng_rd_data);
            if (eng_op_err) begin
              locked_reg <= 1'b0;
              state_reg  <= IDLE;
            end else if (op_reg[OP_LOCK]) begin
              locked_reg <= 1'b1;
              state_reg  <= HOLD;
`ifdef IIC_ARB_HOLD_TIMEOUT_EN
              to_cnt_reg <= '0;
`endif
            end else begin
              locked_reg <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
        HOLD: begin
          if (pop_en) begin
            op_reg        <= pop_word;
            sel_reg       <= pop_idx;
            last_reg      <= pop_idx;
            eng_valid_reg <= 1'b1;
            state_reg     <= BUSY;
`ifdef IIC_ARB_HOLD_TIMEOUT_EN
          end else if (to_cnt_reg == TO_LAST) begin
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end else if (to_cnt_reg != {TO_W{1'b1}}) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign eng_op_valid   = eng_valid_reg;
  assign eng_op_start   = op_reg[OP_START];
  assign eng_op_stop    = op_reg[OP_STOP];
  assign eng_op_rnw     = op_reg[OP_RNW];
  assign eng_op_wr_data = op_reg[7:0];
  assign ch_op_done     = done_reg;
  assign ch_op_err      = err_reg;
  assign ch_rd_data     = rd_reg;
  assign arb_sel        = sel_reg;
  assign arb_locked     = locked_reg;
  assign hold_timeout   = timeout_reg;

endmodule

// File: tb/tb_iic_op_arbiter.sv
// Scoreboard bench for iic_op_arbiter: FIFO and engine models, expected grants
// queued with stimulus, expected completions queued when the engine acks.
module tb_iic_op_arbiter;

  localparam int N_CH    = 4;
  localparam int CH_W    = 2;
  localparam int ENG_LAT = 3;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i;
  logic [N_CH-1:0]      ch_op_valid;
  logic [12*N_CH-1:0]   ch_op_word;
  logic [N_CH-1:0]      ch_op_pop;
  logic [N_CH-1:0]      ch_op_done;
  logic                 ch_op_err;
  logic [7:0]           ch_rd_data;
  logic                 eng_op_valid;
  logic                 eng_op_start;
  logic                 eng_op_stop;
  logic                 eng_op_rnw;
  logic [7:0]           eng_op_wr_data;
  logic                 eng_op_ack;
  logic                 eng_op_err;
  logic [7:0]           eng_rd_data;
  logic [CH_W-1:0]      arb_sel;
  logic                 arb_locked;
  logic                 hold_timeout;

  always #5 wb_clk_i = ~wb_clk_i;

  iic_op_arbiter #(
    .N_CH         (N_CH),
    .CH_W         (CH_W),
    .HOLD_TIMEOUT (8),
    .TO_W         (16)
  ) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .ch_op_valid    (ch_op_valid),
    .ch_op_word     (ch_op_word),
    .ch_op_pop      (ch_op_pop),
    .ch_op_done     (ch_op_done),
    .ch_op_err      (ch_op_err),
    .ch_rd_data     (ch_rd_data),
    .eng_op_valid   (eng_op_valid),
    .eng_op_start   (eng_op_start),
    .eng_op_stop    (eng_op_stop),
    .eng_op_rnw     (eng_op_rnw),
    .eng_op_wr_data (eng_op_wr_data),
    .eng_op_ack     (eng_op_ack),
    .eng_op_err     (eng_op_err),
    .eng_rd_data    (eng_rd_data),
    .arb_sel        (arb_sel),
    .arb_locked     (arb_locked),
    .hold_timeout   (hold_timeout)
  );

  typedef struct packed {
    logic [7:0] ch;
    logic       err;
    logic [7:0] rd;
    logic       locked;
  } done_exp_t;

  logic [11:0] fifo_q [N_CH][$];
  int          exp_gnt_q[$];
  done_exp_t   exp_done_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          cur_ch = 0;
  logic [11:0] cur_word = '0;
  logic        pend_rm;
  int          pend_ch = 0;
  logic        eng_chk;
  int          wait_cnt;
  logic        expect_done;
  logic        spurious_req;
  int          hold_entry_cyc;
  int          to_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] mk(input logic lock, input logic stop, input logic start,
                                     input logic rnw, input logic [7:0] d);
    return {lock, stop, start, rnw, d};
  endfunction

  task automatic refresh();
    for (int c = 0; c < N_CH; c++) begin
      ch_op_valid[c]        = (fifo_q[c].size() != 0);
      ch_op_word[c*12 +: 12] = (fifo_q[c].size() != 0) ? fifo_q[c][0] : 12'h000;
    end
  endtask

  task automatic push_op(input int c, input logic [11:0] w);
    fifo_q[c].push_back(w);
    refresh();
  endtask

  function automatic bit fifo_busy();
    for (int c = 0; c < N_CH; c++)
      if (fifo_q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // FIFO, engine and scoreboard model, all evaluated away from the active edge.
  always @(negedge wb_clk_i) begin
    int        e;
    done_exp_t de;
    cyc++;
    if (wb_rst_i) begin
      eng_op_ack  = 1'b0;
      eng_op_err  = 1'b0;
      eng_rd_data = 8'h00;
      wait_cnt    = 0;
      expect_done = 1'b0;
      eng_chk     = 1'b0;
    end else begin
      if (pend_rm) begin
        if (fifo_q[pend_ch].size() != 0) void'(fifo_q[pend_ch].pop_front());
        pend_rm = 1'b0;
        refresh();
      end
      if (eng_chk) begin
        chk("eng_valid", eng_op_valid, 1);
        chk("eng_fields", {eng_op_start, eng_op_stop, eng_op_rnw, eng_op_wr_data},
            {cur_word[9], cur_word[10], cur_word[8], cur_word[7:0]});
        chk("arb_sel", arb_sel, cur_ch);
        eng_chk = 1'b0;
      end
      if (ch_op_pop != '0) begin
        chk("pop_onehot", $countones(ch_op_pop), 1);
        chk("pop_in_busy", eng_op_valid, 0);
        if (exp_gnt_q.size() == 0) begin
          chk("pop_unexpected", ch_op_pop, 0);
        end else begin
          e = exp_gnt_q.pop_front();
          chk("gnt_ch", ch_op_pop, 1 << e);
          cur_ch   = e;
          cur_word = (fifo_q[e].size() != 0) ? fifo_q[e][0] : 12'h000;
          pend_rm  = 1'b1;
          pend_ch  = e;
          eng_chk  = 1'b1;
          $display("grant  ch=%0d word=%03h cycle=%0d", e, cur_word, cyc);
        end
      end
      if (expect_done) begin
        de = exp_done_q.pop_front();
        chk("done_vec", ch_op_done, 1 << de.ch);
        chk("done_err", ch_op_err, de.err);
        chk("done_rd", ch_rd_data, de.rd);
        chk("done_locked", arb_locked, de.locked);
        if (de.locked) hold_entry_cyc = cyc;
        expect_done = 1'b0;
        $display("done   ch=%0d err=%0d rd=%02h locked=%0d cycle=%0d",
                 de.ch, ch_op_err, ch_rd_data, arb_locked, cyc);
      end else if (ch_op_done != '0) begin
        chk("done_spurious", ch_op_done, 0);
      end
      if (hold_timeout) begin
`ifdef IIC_ARB_HOLD_TIMEOUT_EN
        chk("to_delay", cyc - hold_entry_cyc, 8);
        chk("to_unlock", arb_locked, 0);
        to_seen++;
        $display("revoke lock cycle=%0d", cyc);
`else
        chk("to_tied", hold_timeout, 0);
`endif
      end
      // Engine: acks ENG_LAT cycles into each op; data 0xEE provokes an error.
      if (eng_op_ack) begin
        eng_op_ack  = 1'b0;
        eng_op_err  = 1'b0;
        eng_rd_data = 8'h00;
      end else if (eng_op_valid) begin
        wait_cnt++;
        if (wait_cnt == ENG_LAT) begin
          wait_cnt    = 0;
          eng_op_ack  = 1'b1;
          eng_op_err  = (cur_word[7:0] == 8'hEE);
          eng_rd_data = 8'h5C;
          de.ch     = 8'(cur_ch);
          de.err    = eng_op_err;
          de.rd     = cur_word[8] ? 8'h5C : 8'h00;
          de.locked = !eng_op_err && cur_word[11];
          exp_done_q.push_back(de);
          expect_done = 1'b1;
        end
      end else if (spurious_req) begin
        eng_op_ack   = 1'b1;
        eng_op_err   = 1'b1;
        eng_rd_data  = 8'hFF;
        spurious_req = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_gnt_q.size() != 0 || exp_done_q.size() != 0 || expect_done ||
            eng_op_valid || pend_rm || fifo_busy()) && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk({tag, "_drain"}, n < budget, 1);
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic wait_pop(input string tag, input int budget);
    int n = 0;
    while (exp_gnt_q.size() != 0 && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk({tag, "_pop"}, n < budget, 1);
  endtask

  task automatic at_push_slot();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ch"}, {ch_op_pop, ch_op_done, ch_op_err, ch_rd_data}, 0);
    chk({tag, "_eng"}, {eng_op_valid, eng_op_start, eng_op_stop, eng_op_rnw,
                        eng_op_wr_data, arb_sel, arb_locked, hold_timeout}, 0);
  endtask

  initial begin
    int n;
    wb_rst_i     = 1'b1;
    ch_op_valid  = '0;
    ch_op_word   = '0;
    eng_op_ack   = 1'b0;
    eng_op_err   = 1'b0;
    eng_rd_data  = 8'h00;
    pend_rm      = 1'b0;
    eng_chk      = 1'b0;
    wait_cnt     = 0;
    expect_done  = 1'b0;
    spurious_req = 1'b0;
    hold_entry_cyc = 0;
    to_seen      = 0;

    repeat (3) @(negedge wb_clk_i);
    #1;
    chk_all_zero("reset");
    wb_rst_i = 1'b0;

    // Two unlocked requesters alternate.
    at_push_slot();
    push_op(1, mk(0, 0, 1, 0, 8'h11));
    push_op(1, mk(0, 1, 0, 0, 8'h12));
    push_op(3, mk(0, 0, 1, 0, 8'h31));
    push_op(3, mk(0, 1, 0, 0, 8'h32));
    exp_gnt_q = '{1, 3, 1, 3};
    wait_drain("rr", 200);

    // Locked sequence from ch0 keeps ch2 waiting until the unlocked op acks.
    at_push_slot();
    push_op(0, mk(1, 0, 1, 0, 8'hA0));
    push_op(0, mk(1, 0, 0, 0, 8'hA1));
    push_op(0, mk(0, 1, 0, 0, 8'hA2));
    push_op(2, mk(0, 0, 1, 0, 8'h21));
    push_op(2, mk(0, 1, 0, 0, 8'h22));
    exp_gnt_q = '{0, 0, 0, 2, 2};
    wait_drain("lock", 200);
    chk("lock_released", arb_locked, 0);

    // Error on a locked op drops the lock; round-robin resumes after ch2.
    at_push_slot();
    push_op(2, mk(1, 0, 1, 0, 8'hEE));
    exp_gnt_q = '{2};
    wait_pop("err", 50);
    at_push_slot();
    push_op(1, mk(0, 0, 1, 0, 8'h13));
    push_op(3, mk(0, 0, 1, 0, 8'h33));
    push_op(2, mk(0, 0, 1, 0, 8'h23));
    exp_gnt_q = '{3, 1, 2};
    wait_drain("err", 200);

    // Read returns engine data; the write after it returns 0.
    at_push_slot();
    push_op(1, mk(0, 0, 1, 1, 8'h00));
    push_op(1, mk(0, 1, 0, 0, 8'h14));
    exp_gnt_q = '{1, 1};
    wait_drain("read", 200);

    // An ack outside BUSY must not produce a completion.
    at_push_slot();
    spurious_req = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    chk("spur_valid", eng_op_valid, 0);
    chk("spur_consumed", spurious_req, 0);

    // Reset while BUSY clears everything; ch0 wins afterwards.
    at_push_slot();
    push_op(3, mk(1, 0, 1, 0, 8'h34));
    exp_gnt_q = '{3};
    n = 0;
    while (!eng_op_valid && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("busy_reached", eng_op_valid, 1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk_all_zero("rst_busy");
    exp_gnt_q.delete();
    exp_done_q.delete();
    push_op(0, mk(0, 0, 1, 0, 8'h01));
    push_op(1, mk(0, 0, 1, 0, 8'h02));
    push_op(2, mk(0, 0, 1, 0, 8'h03));
    push_op(3, mk(0, 0, 1, 0, 8'h04));
    @(negedge wb_clk_i);
    #1;
    chk("rst_pop_gated", ch_op_pop, 0);
    exp_gnt_q = '{0, 1, 2, 3};
    at_push_slot();
    wb_rst_i = 1'b0;
    wait_drain("post_rst", 200);

`ifdef IIC_ARB_HOLD_TIMEOUT_EN
    // Silent lock owner is revoked; the waiting channel is served.
    at_push_slot();
    push_op(3, mk(1, 0, 1, 0, 8'h3A));
    exp_gnt_q = '{3};
    wait_pop("to", 50);
    at_push_slot();
    push_op(0, mk(0, 0, 1, 0, 8'h0A));
    exp_gnt_q = '{0};
    wait_drain("to", 200);
    chk("to_count", to_seen, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iic_op_arbiter.md
Name: iic_op_arbiter

Overview:
- Parametrised N-channel successor to the two-way CPU/fabric op arbiter in front of the I2C byte engine (miic_ops).
- Accepts 12-bit I2C op words from N_CH first-word-fall-through op FIFOs (CPU, gain loaders, monitors).
- Grants channels round-robin and honours the per-op lock bit so that multi-byte transactions are atomic.
- Registers the granted op for the engine and returns completion, read data and error to the owning channel.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- CH_W, $clog2(N_CH), width of the channel index.
- HOLD_TIMEOUT, 65535, cycles a locked grant may sit idle before being revoked (only with the macro).
- TO_W, 16, width of the hold-timeout counter.

Ports:
- wb_clk_i  in  1  core clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- ch_op_valid  in  N_CH  channel FIFO non-empty
- ch_op_word  in  12*N_CH  per channel {lock, stop, start, rnw, data[7:0]}; channel c occupies [12c+11:12c]
- ch_op_pop  out  N_CH  one-cycle FIFO read strobe
- ch_op_done  out  N_CH  one-cycle completion pulse
- ch_op_err  out  1  qualifies ch_op_done: NACK/bus error
- ch_rd_data  out  8  read byte, valid with ch_op_done
- eng_op_valid  out  1  op presented to engine
- eng_op_start, eng_op_stop, eng_op_rnw  out  1 each  registered op fields
- eng_op_wr_data  out  8  registered write byte
- eng_op_ack  in  1  engine completion pulse
- eng_op_err  in  1  engine error, sampled with eng_op_ack
- eng_rd_data  in  8  engine read byte, sampled with eng_op_ack
- arb_sel  out  CH_W  current or last grant
- arb_locked  out  1  lock held
- hold_timeout  out  1  pulse when a lock is revoked

Behaviour:
- Reset (async) values:
  - All outputs 0.
  - State IDLE, arb_sel=0, locked=0.
  - Round-robin pointer last=N_CH-1, so ch0 has first priority.
- State IDLE:
  - If any ch_op_valid, pick the first valid channel searching from last+1 modulo N_CH.
  - Same cycle: ch_op_pop[c]=1 (combinational from state and valid), capture ch_op_word[c] into op_reg, arb_sel<=c, last<=c, go to BUSY.
- State BUSY:
  - eng_op_valid=1; op fields driven from op_reg and held stable until eng_op_ack.
  - On eng_op_ack: next cycle ch_op_done[arb_sel]=1, with ch_rd_data=eng_rd_data (0 when the op was a write) and ch_op_err=eng_op_err.
  - After ack:
    - if err, locked<=0 and go to IDLE;
    - else if op_reg.lock, locked<=1 and go to HOLD;
    - else locked<=0 and go to IDLE.
- State HOLD:
  - Only channel arb_sel is eligible; other channels wait.
  - If ch_op_valid[arb_sel], pop and capture as in IDLE, go to BUSY.
- Latency:
  - Pop to eng_op_valid: 1 cycle.
  - eng_op_ack to ch_op_done: 1 cycle.
  - Done to next pop: 0 cycles, since a pop may occur in the same cycle as the done pulse.
- Boundary rules:
  - An eng_op_ack arriving outside BUSY is ignored.
  - A pop never occurs while in BUSY, so at most one op is outstanding.
  - A lock on an op carrying stop=1 is still honoured; the owning channel releases it with a later op whose lock=0.
  - ch_op_valid dropping while in BUSY has no effect, because the op is already captured.
  - Reset asserted mid-transaction aborts immediately; the engine must be reset by the same reset.
- N_CH=1 degenerates to pass-through with registering; round-robin search is trivial.

Optional Feature:
- Macro IIC_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A TO_W counter clears on entry to HOLD and increments each HOLD cycle.
  - When it reaches HOLD_TIMEOUT-1 without a pop: locked<=0, go to IDLE, hold_timeout pulses for 1 cycle.
  - The counter is saturating and never wraps.
- Undefined:
  - No counter is built; HOLD persists indefinitely.
  - hold_timeout is tied to 0.

Decomposition:
- Package iic_pkg:
  - OP_W=12.
  - Field index constants OP_LOCK=11, OP_STOP=10, OP_START=9, OP_RNW=8.
  - State enum IDLE/BUSY/HOLD.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[N_CH], last[CH_W].
  - Outputs: gnt_idx, any.

Test Plan:
- Requests: N_CH=4, ch1 and ch3 both valid with lock=0, two ops each.
  - Required grant order 1,3,1,3.
  - Each pop is followed one cycle later by eng_op_valid.
- Lock hold: ch0 issues op 0xA0 with lock=1 while ch2 is continuously valid.
  - ch0 retains the grant for its following ops until one with lock=0 acks.
  - ch2 is popped only after that.
- Engine error: eng_op_err=1 with ack on a locked op from ch2.
  - ch_op_done[2]=1 with ch_op_err=1.
  - arb_locked=0.
  - The next grant goes to the round-robin winner.
- Read: ch1 issues a read (rnw=1); engine returns eng_rd_data=0x5C.
  - ch_op_done[1] and ch_rd_data=0x5C appear exactly one cycle after ack.
- Reset: assert wb_rst_i while in BUSY.
  - All outputs are 0 asynchronously.
  - After release, the first grant goes to ch0 when all channels are valid.
- With IIC_ARB_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=8: ch3 locks, then goes silent.
  - hold_timeout pulses 8 cycles after entering HOLD.
  - ch0 is granted next.
